// File: rtl/dmem_ctrl_if.sv
// Core-to-data-memory port: request signals from the core, read response from the controller.
interface dmem_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      mem_re_in;
    logic                      mem_we_in;
    logic [DATA_WIDTH-1:0]     mem_addr_in;
    logic [DATA_WIDTH-1:0]     mem_data_in;
    logic [DATA_WIDTH/8-1:0]   mem_mask_in;
    logic [DATA_WIDTH-1:0]     mem_data_out;
    logic                      mem_read_resp;
    logic                      mem_busy;

    modport master (
        output mem_re_in, mem_we_in, mem_addr_in, mem_data_in, mem_mask_in,
        input  mem_data_out, mem_read_resp, mem_busy
    );

    modport slave (
        input  mem_re_in, mem_we_in, mem_addr_in, mem_data_in, mem_mask_in,
        output mem_data_out, mem_read_resp, mem_busy
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-maskable word SRAM behind the core's data port; loads complete after a
// fixed READ_LAT cycles with a one-cycle response pulse, stores never stall.
module dmem_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int DMEM_SZ_IN_KB = 1,
    parameter int READ_LAT      = 2
) (
    input  logic             clk,
    input  logic             arst,
    dmem_ctrl_if.slave       bus
);
    localparam int DEPTH = DMEM_SZ_IN_KB * 1024 * 8 / DATA_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int MW    = DATA_WIDTH / 8;
    localparam int CW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic [AW-1:0]         addr_idx;
    logic [AW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic                  addr_unused;

    assign addr_idx    = bus.mem_addr_in[AW+1:2];
    assign addr_unused = ^{bus.mem_addr_in[DATA_WIDTH-1:AW+2], bus.mem_addr_in[1:0]};

    // NOTE: the array has no reset; contents must survive arst, and a reset
    // branch would also stop the array from mapping onto SRAM.
    always_ff @(posedge clk) begin
        if (bus.mem_we_in) begin
            for (int i = 0; i < MW; i++) begin
                if (bus.mem_mask_in[i]) begin
                    mem_q[addr_idx][i*8 +: 8] <= bus.mem_data_in[i*8 +: 8];
                end
            end
        end
    end

    // The returned word must include a write landing on the same edge, so merge
    // the incoming write lanes over the stored word.
    assign rd_idx = (state_q == IDLE) ? addr_idx : idx_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        fwd_word = mem_q[rd_idx];
        if (bus.mem_we_in && (addr_idx == rd_idx)) begin
            for (int i = 0; i < MW; i++) begin
                if (bus.mem_mask_in[i]) begin
                    fwd_word[i*8 +: 8] = bus.mem_data_in[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_re_in) begin
                    idx_d   = addr_idx;
                    cnt_d   = CW'(READ_LAT - 1);
                    state_d = (READ_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RESP) begin
            data_out_d = fwd_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.mem_data_out  = data_out_q;
    assign bus.mem_read_resp = (state_q == RESP);
    assign bus.mem_busy      = (state_q != IDLE);
endmodule
